// File: rtl/fp_pkg.sv
// Shared constants, state encoding and field helpers for the FP multiply/divide datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam int FP_BIAS   = 127;

    // Exception codes shared with the divider; 00 is "none" here since a multiply cannot divide by zero
    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_UNDF = 2'b01;
    localparam logic [1:0] EXC_OVF  = 2'b10;
    localparam logic [1:0] EXC_NAN  = 2'b11;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_MULT,
        ST_NORM,
        ST_FINISH
    } state_t;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [FP_MANT_W-1:0] fp_mant(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage

// File: rtl/fp_shift_add_core.sv
// Unsigned W x W shift-add multiplier engine producing a 2W-bit product.
// Latency: load cycle, then W iterate cycles; product valid the cycle after 'last' was high while iterating.
// Backpressure: none; the caller holds iterate high only while it wants progress.
module fp_shift_add_core #(
    parameter int W = 24
) (
    input  logic           CLOCK,
    input  logic           RESET,
    input  logic           load,
    input  logic           iterate,
    input  logic [W-1:0]   mcand,
    input  logic [W-1:0]   mplier,
    output logic [2*W-1:0] product,
    output logic           last
);

    localparam int CW = $clog2(W);

    logic [W-1:0]   mcand_q;
    logic [W-1:0]   mplier_q;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;

    // One partial product per cycle: add the shifted multiplicand when the current multiplier bit is set
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt      <= '0;
            acc      <= '0;
        end else if (load) begin
            mcand_q  <= mcand;
            mplier_q <= mplier;
            cnt      <= '0;
            acc      <= '0;
        end else if (iterate) begin
            if (mplier_q[cnt]) begin
                acc <= acc + ({{W{1'b0}}, mcand_q} << cnt);
            end
            cnt <= cnt + 1'b1;
        end
    end

    assign product = acc;
    assign last    = (cnt == CW'(W - 1));

endmodule

// File: rtl/fp_multiplier_seq.sv
// Iterative IEEE-754 single-precision multiplier with truncating rounding and divider-compatible exception codes.
// Latency: 2 cycles START-to-DONE for special operands, 27 cycles for the normal shift-add path.
// Backpressure: START is only sampled in IDLE; requests while BUSY are dropped.
module fp_multiplier_seq
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W,
    parameter int BIAS   = FP_BIAS
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] InputA,
    input  logic [31:0] InputB,
    output logic [31:0] AxB,
    output logic        DONE,
    output logic        BUSY,
    output logic [1:0]  Exception
);

    localparam int SIG_W = MANT_W + 1;
    localparam int EW    = EXP_W + 2;
    localparam logic [EXP_W-1:0]     EXP_MAX = '1;
    localparam logic signed [EW-1:0] E_BIAS  = EW'(BIAS);
    localparam logic signed [EW-1:0] E_OVF   = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ONE   = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO  = '0;

    state_t state, state_nxt;

    logic [31:0]        a_q, b_q;
    logic               sign;
    logic [EXP_W-1:0]   ea, eb;
    logic [MANT_W-1:0]  ma, mb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    logic               spec_vld;
    logic [31:0]        spec_res;
    logic [1:0]         spec_exc;

    logic [2*SIG_W-1:0] prod;
    logic               core_last;
    logic               prod_unused;

    logic signed [EW-1:0] e_raw, e_norm;
    logic [MANT_W-1:0]    m_norm;
    logic [31:0]          norm_res;
    logic [1:0]           norm_exc;

    assign sign = fp_sign(a_q) ^ fp_sign(b_q);
    assign ea   = fp_exp(a_q);
    assign eb   = fp_exp(b_q);
    assign ma   = fp_mant(a_q);
    assign mb   = fp_mant(b_q);

    // Exponent zero covers true zero and subnormals, which are flushed to zero
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_MAX) && (ma == '0);
    assign b_inf  = (eb == EXP_MAX) && (mb == '0);
    assign a_nan  = (ea == EXP_MAX) && (ma != '0);
    assign b_nan  = (eb == EXP_MAX) && (mb != '0);

    // Special-operand decode, in priority order NaN, Inf x 0, Inf, zero
    always_comb begin
        spec_vld = 1'b1;
        spec_res = QNAN;
        spec_exc = EXC_NAN;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            spec_res = QNAN;
        end else if (a_inf || b_inf) begin
            spec_res = {sign, EXP_MAX, {MANT_W{1'b0}}};
            spec_exc = EXC_OVF;
        end else if (a_zero || b_zero) begin
            spec_res = {sign, {(EXP_W + MANT_W){1'b0}}};
            spec_exc = EXC_NONE;
        end else begin
            spec_vld = 1'b0;
        end
    end

    fp_shift_add_core #(.W(SIG_W)) u_core (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .load    (state == ST_CHECK),
        .iterate (state == ST_MULT),
        .mcand   ({1'b1, ma}),
        .mplier  ({1'b1, mb}),
        .product (prod),
        .last    (core_last)
    );

    // Bits below the kept mantissa are discarded by truncation
    assign prod_unused = ^prod[MANT_W-1:0];

    assign e_raw = $signed({2'b00, ea}) + $signed({2'b00, eb}) - E_BIAS;

    // Normalise the 48-bit product, then clamp the exponent into overflow/underflow
    always_comb begin
        e_norm   = e_raw;
        m_norm   = prod[2*SIG_W-3 -: MANT_W];
        norm_res = '0;
        norm_exc = EXC_NONE;
        if (prod[2*SIG_W-1]) begin
            m_norm = prod[2*SIG_W-2 -: MANT_W];
            e_norm = e_raw + E_ONE;
        end
        if (e_norm >= E_OVF) begin
            norm_res = {sign, EXP_MAX, {MANT_W{1'b0}}};
            norm_exc = EXC_OVF;
        end else if (e_norm <= E_ZERO) begin
            norm_res = {sign, {(EXP_W + MANT_W){1'b0}}};
            norm_exc = EXC_UNDF;
        end else begin
            norm_res = {sign, e_norm[EXP_W-1:0], m_norm};
            norm_exc = EXC_NONE;
        end
    end

    // State register
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_nxt = state;
        DONE      = 1'b0;
        BUSY      = 1'b1;
        case (state)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (START) state_nxt = ST_CHECK;
            end
            ST_CHECK:  state_nxt = spec_vld ? ST_FINISH : ST_MULT;
            ST_MULT:   if (core_last) state_nxt = ST_NORM;
            ST_NORM:   state_nxt = ST_FINISH;
            ST_FINISH: begin
                DONE      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture and result registers; results only move when heading into FINISH
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            a_q       <= '0;
            b_q       <= '0;
            AxB       <= '0;
            Exception <= EXC_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        a_q <= InputA;
                        b_q <= InputB;
                    end
                end
                ST_CHECK: begin
                    if (spec_vld) begin
                        AxB       <= spec_res;
                        Exception <= spec_exc;
                    end
                end
                ST_NORM: begin
                    AxB       <= norm_res;
                    Exception <= norm_exc;
                end
                default: ;
            endcase
        end
    end

endmodule
